// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch defaults, fetch FSM states, opcode constants
// and a program-memory range helper.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int          IMEM_WORDS_DEFAULT = 20;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_NOR  = 6'h01;
    localparam logic [5:0] OP_NORI = 6'h0E;
    localparam logic [5:0] OP_ROLV = 6'h05;
    localparam logic [5:0] OP_RORV = 6'h06;
    localparam logic [5:0] OP_NOT  = 6'h07;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BLEU = 6'h09;
    localparam logic [5:0] OP_JR   = 6'h0A;

    // Byte PC is fetchable only below 4*words; wrapped PCs fall outside too.
    function automatic logic pc_in_range(input logic [31:0] pc, input int words);
        logic [31:0] limit;
        limit = 32'(words) << 2;
        return pc < limit;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: fetch side drives the byte address, memory answers
// combinationally with the word at that address.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, decode stall, execute redirects and
// a HALT state entered when the PC leaves the program memory.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4,
    output logic                halted,
    output logic                misalign_err,
    output logic [15:0]         fetch_count,
    output fetch_state_t        fsm_state
);

    // Handshake: redirect_valid is a one-cycle command sampled at the edge and
    // always accepted; stall=1 means decode refuses the word, so fetch holds.

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  target_aligned;
    logic         target_ok;
    logic         misaligned;
    logic         do_fetch;
    logic         clear_valid;

    assign target_aligned = {redirect_target[31:2], 2'b00};
    assign target_ok      = pc_in_range(target_aligned, IMEM_WORDS);
    assign misaligned     = redirect_valid && (redirect_target[1:0] != 2'b00);

    assign imem.imem_addr = pc;
    assign halted         = (state == HALT);
    assign fsm_state      = state;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        do_fetch    = 1'b0;
        clear_valid = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_next     = target_aligned;
                    clear_valid = 1'b1;
                end else if (!stall) begin
                    if (pc_in_range(pc, IMEM_WORDS)) begin
                        do_fetch = 1'b1;
                        pc_next  = pc + 32'd4;
                    end else begin
                        state_next  = HALT;
                        clear_valid = 1'b1;
                    end
                end
            end
            HALT: begin
                clear_valid = 1'b1;
                // An out-of-range target leaves the unit parked in HALT.
                if (redirect_valid && target_ok) begin
                    state_next = RUN;
                    pc_next    = target_aligned;
                end
            end
            default: begin
                state_next = RUN;
                pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= 32'h0;
            if_pc_plus4  <= 32'h0;
            misalign_err <= 1'b0;
            fetch_count  <= 16'h0;
        end else begin
            if (misaligned) begin
                misalign_err <= 1'b1;
            end
            if (do_fetch) begin
                if_valid    <= 1'b1;
                if_instr    <= imem.imem_data;
                if_pc       <= pc;
                if_pc_plus4 <= pc + 32'd4;
                if (fetch_count != 16'hFFFF) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end else if (clear_valid) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stall/redirect run checked against a behavioural fetch model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          WORDS = 20;
    localparam logic [31:0] LIMIT = 32'(4 * WORDS);

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         if_valid;
    logic [31:0]  if_instr;
    logic [31:0]  if_pc;
    logic [31:0]  if_pc_plus4;
    logic         halted;
    logic         misalign_err;
    logic [15:0]  fetch_count;
    fetch_state_t fsm_state;

    fetch_unit_if imem_bus ();

    logic [31:0] mem [WORDS];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_pc, m_instr, m_ipc, m_p4;
    logic        m_valid, m_halt, m_err;
    logic [15:0] m_cnt;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (imem_bus.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a poison word that must never be issued.
    assign imem_bus.imem_data = (imem_bus.imem_addr < LIMIT) ?
                                mem[imem_bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_p4 = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
    endtask

    // One clock edge of the fetch rules, applied to the current inputs.
    task automatic model_edge();
        logic [31:0] t;
        t = redirect_target & ~32'h3;
        if (redirect_valid && redirect_target[1:0] != 2'b00) m_err = 1'b1;
        if (m_halt) begin
            m_valid = 1'b0;
            if (redirect_valid && t < LIMIT) begin
                m_halt = 1'b0;
                m_pc   = t;
            end
        end else if (redirect_valid) begin
            m_pc    = t;
            m_valid = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (m_pc >= LIMIT) begin
            m_halt  = 1'b1;
            m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_p4    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", if_valid); end
        total++; if (fetch_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", fetch_count); end
        total++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b want=00", halted, misalign_err); end
        reset = 1'b0;
        total++; if (imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=00000000", imem_bus.imem_addr); end
    endtask

    task automatic test_first_fetch();
        tick();
        total++; if (if_instr !== 32'h8C01_0008) begin bad++; $display("FAIL first_instr got=%h want=8c010008", if_instr); end
        total++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin bad++; $display("FAIL first_pc got=%h/%h want=0/4", if_pc, if_pc_plus4); end
        total++; if (if_valid !== 1'b1 || fetch_count !== 16'd1) begin bad++; $display("FAIL first_valid_count got=%0b/%0d want=1/1", if_valid, fetch_count); end
    endtask

    task automatic test_stall();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (if_pc !== 32'h4 || if_instr !== mem[1] || imem_bus.imem_addr !== 32'h8) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got pc=%h instr=%h addr=%h want pc=4 instr=%h addr=8",
                         i, if_pc, if_instr, imem_bus.imem_addr, mem[1]);
            end
            total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL stall_count got=%0d want=2", fetch_count); end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h44;
        tick();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_bus.imem_addr !== 32'h44) begin bad++; $display("FAIL rs_bubble got valid=%0b addr=%h want 0/44", if_valid, imem_bus.imem_addr); end
        stall = 1'b0;
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== mem[17]) begin bad++; $display("FAIL rs_target got valid=%0b pc=%h instr=%h want 1/44/%h", if_valid, if_pc, if_instr, mem[17]); end
    endtask

    task automatic test_redirect_halt();
        redirect_valid = 1'b1; redirect_target = 32'h4C;
        tick();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rd_bubble got=%0b want=0", if_valid); end
        tick();
        total++; if (if_instr !== 32'h20E0_0000 || if_pc !== 32'h4C || if_pc_plus4 !== 32'h50) begin bad++; $display("FAIL rd_target got instr=%h pc=%h p4=%h want 20e00000/4c/50", if_instr, if_pc, if_pc_plus4); end
        tick();
        total++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_bus.imem_addr !== 32'h50) begin bad++; $display("FAIL rd_halt got halted=%0b valid=%0b addr=%h want 1/0/50", halted, if_valid, imem_bus.imem_addr); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        total++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rd_resume got halted=%0b valid=%0b addr=%h want 0/0/0", halted, if_valid, imem_bus.imem_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL rd_resume_fetch got valid=%0b pc=%h want 1/0", if_valid, if_pc); end
    endtask

    task automatic test_sequential();
        int cycles;
        logic [31:0] exp_instr;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) exp_q.push_back(mem[i]);
        cycles = 0;
        while (halted !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
            if (if_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL seq_extra got pc=%h instr=%h want none", if_pc, if_instr);
                end else begin
                    exp_instr = exp_q.pop_front();
                    if (if_instr !== exp_instr || if_pc !== 32'(4 * (WORDS - 1 - exp_q.size()))) begin
                        bad++; $display("FAIL seq_issue got pc=%h instr=%h want instr=%h", if_pc, if_instr, exp_instr);
                    end
                end
            end
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL seq_timeout got halted=%0b after %0d cycles want 1", halted, cycles); end
        total++; if (exp_q.size() != 0 || fetch_count !== 16'd20) begin bad++; $display("FAIL seq_complete got left=%0d count=%0d want 0/20", exp_q.size(), fetch_count); end
        total++; if (if_pc !== 32'h4C || if_valid !== 1'b0) begin bad++; $display("FAIL seq_last got pc=%h valid=%0b want 4c/0", if_pc, if_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h50;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL seq_oob_redirect got halted=%0b want 1", halted); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h4E;
        tick();
        redirect_valid = 1'b0;
        total++; if (misalign_err !== 1'b1 || halted !== 1'b0 || imem_bus.imem_addr !== 32'h4C) begin bad++; $display("FAIL mis_set got err=%0b halted=%0b addr=%h want 1/0/4c", misalign_err, halted, imem_bus.imem_addr); end
        tick();
        total++; if (if_pc !== 32'h4C || if_instr !== 32'h20E0_0000) begin bad++; $display("FAIL mis_fetch got pc=%h instr=%h want 4c/20e00000", if_pc, if_instr); end
        redirect_valid = 1'b1; redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        total++; if (misalign_err !== 1'b1 || fetch_count === 16'h0) begin bad++; $display("FAIL mis_sticky got err=%0b count=%0d want 1/nonzero", misalign_err, fetch_count); end
        // Pending stall + redirect when reset hits mid-cycle must be dropped.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 ||
            halted !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 16'h0 || imem_bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got v=%0b i=%h pc=%h p4=%h h=%0b e=%0b c=%0d a=%h want all zero",
                     if_valid, if_instr, if_pc, if_pc_plus4, halted, misalign_err, fetch_count, imem_bus.imem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        tick();
        total++; if (if_pc !== 32'h0 || if_valid !== 1'b1 || if_instr !== 32'h8C01_0008) begin bad++; $display("FAIL reset_discard got pc=%h valid=%0b instr=%h want 0/1/8c010008", if_pc, if_valid, if_instr); end
    endtask

    task automatic test_random();
        int errs;
        apply_reset();
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = 32'($urandom_range(0, 23)) * 32'd4;
            if ($urandom_range(0, 7) == 0) redirect_target = redirect_target + 32'($urandom_range(1, 3));
            tick();
            total++;
            if (if_valid !== m_valid || if_instr !== m_instr || if_pc !== m_ipc || if_pc_plus4 !== m_p4 ||
                halted !== m_halt || misalign_err !== m_err || fetch_count !== m_cnt ||
                imem_bus.imem_addr !== m_pc || fsm_state !== (m_halt ? HALT : RUN)) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand cyc=%0d got v=%0b i=%h pc=%h h=%0b e=%0b c=%0d a=%h want v=%0b i=%h pc=%h h=%0b e=%0b c=%0d a=%h",
                             i, if_valid, if_instr, if_pc, halted, misalign_err, fetch_count, imem_bus.imem_addr,
                             m_valid, m_instr, m_ipc, m_halt, m_err, m_cnt, m_pc);
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h8C01_0008;
        mem[19] = 32'h20E0_0000;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_stall();
        test_redirect_halt();
        test_sequential();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 Parameter IMEM_WORDS, default 20, number of valid instruction words; legal byte PCs are 0 to 4*IMEM_WORDS-4.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port imem_addr, output, 32, byte address to instruction memory; equals PC register, combinational.
REQ-006 Port imem_data, input, 32, instruction word returned combinationally for imem_addr.
REQ-007 Port stall, input, 1, decode not ready; hold fetch state.
REQ-008 Port redirect_valid, input, 1, taken branch/jump/jal/jr from execute.
REQ-009 Port redirect_target, input, 32, new byte PC when redirect_valid=1.
REQ-010 Port if_valid, output, 1, if_instr/if_pc/if_pc_plus4 hold a real instruction.
REQ-011 Port if_instr, output, 32, registered instruction word.
REQ-012 Port if_pc, output, 32, byte PC of if_instr.
REQ-013 Port if_pc_plus4, output, 32, if_pc+4 (jal link value).
REQ-014 Port halted, output, 1, high while in HALT state.
REQ-015 Port misalign_err, output, 1, sticky flag: a redirect target had nonzero bits [1:0].
REQ-016 Port fetch_count, output, 16, count of instructions issued with if_valid=1; saturates at 16'hFFFF.

Function
REQ-017 FSM SHALL have two states, RUN and HALT; reset state RUN.
REQ-018 In RUN, with stall=0 and redirect_valid=0, each edge SHALL load if_instr<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4; fetch latency one cycle.
REQ-019 With stall=1 and redirect_valid=0, pc, if_* outputs and fetch_count SHALL hold unchanged.
REQ-020 redirect_valid=1 SHALL take priority over stall: next edge pc<={redirect_target[31:2],2'b00}, if_valid<=0 (one bubble); target instruction valid on the following edge.
REQ-021 Redirect with redirect_target[1:0]!=0 SHALL set misalign_err, which stays 1 until reset.
REQ-022 If the PC to be fetched is >= 4*IMEM_WORDS in RUN, the edge SHALL enter HALT, set if_valid<=0 and hold pc; no out-of-range word is ever issued.
REQ-023 In HALT, if_valid=0, pc held, stall ignored; redirect_valid=1 with an in-range target SHALL return to RUN with pc<=target. An out-of-range target SHALL stay in HALT.
REQ-024 fetch_count SHALL increment on each edge where if_valid becomes or stays 1 with a newly loaded instruction, not while stalled.
REQ-025 PC arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32; wrap lands out of range, so HALT applies.

Reset
REQ-026 reset=1 SHALL immediately set pc=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, halted=0, misalign_err=0, fetch_count=0, regardless of clock.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; first fetch after deassertion is RESET_PC.

Structure
REQ-028 Shared package cpu_pkg SHALL hold RESET_PC and IMEM_WORDS defaults, the fetch_state_t enum (RUN, HALT) and the opcode constants (lw, sw, add, nor, nori, rolv, rorv, not, jal, bleu, jr).
REQ-029 No sub-module; the instruction memory is instantiated beside fetch_unit, not inside it.

Verification
REQ-030 Reset release with memory program loaded -> imem_addr=0; after the first edge, if_instr=32'h8C01_0008, if_pc=0, if_valid=1, fetch_count=1.
REQ-031 stall=1 for 3 cycles at pc=0x08 -> if_instr, if_pc=0x04 and imem_addr=0x08 are constant; fetch_count does not change.
REQ-032 redirect_valid=1, target=0x4C -> next cycle if_valid=0; the following cycle if_instr=32'h20E0_0000, if_pc=0x4C, if_pc_plus4=0x50.
REQ-033 redirect and stall asserted together, target=0x44 -> redirect wins; a bubble, then if_pc=0x44.
REQ-034 Sequential run from 0 -> index 19 is issued at if_pc=0x4C, then halted=1, if_valid=0; a later redirect to 0x00 resumes RUN.
REQ-035 Redirect target=0x4E -> misalign_err=1, fetch from 0x4C; flag persists until reset pulse mid-run clears all outputs asynchronously.
